// File: rtl/map_fade_scheduler.sv
// Level/map transition sequencer for the colour path: fades the screen out,
// swaps the map/palette selects on a frame boundary, fades back in, and
// scales the palette colour by the current fade level on its way to the VGA pins.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | full brightness, waiting for a map_req that changes something
// FADE_OUT | stepping fade_level down once every FRAMES_PER_STEP frames
// SWAP     | black screen, map/palette selects update on next frame_start
// FADE_IN  | stepping fade_level up until MAX_LEVEL, then back to IDLE
module map_fade_scheduler #(
   parameter int LEVEL_SHIFT     = 4,
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   frame_start,
   input  logic                   map_req,
   input  logic [1:0]             map_req_idx,
   input  logic [2:0]             pal_req_idx,
   input  logic                   pix_valid_in,
   input  logic [7:0]             R_in,
   input  logic [7:0]             G_in,
   input  logic [7:0]             B_in,
   output logic [1:0]             Map_idx,
   output logic [2:0]             Palette_idx,
   output logic [LEVEL_SHIFT:0]   fade_level,
   output logic                   busy,
   output logic                   swap_done,
   output logic [7:0]             VGA_R,
   output logic [7:0]             VGA_G,
   output logic [7:0]             VGA_B,
   output logic                   pix_valid_out
);

   localparam int LW = LEVEL_SHIFT + 1;
   localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int PW = 8 + LW;
   localparam logic [LW-1:0] LVL_MAX  = LW'(1 << LEVEL_SHIFT);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_PRE  = LW'((1 << LEVEL_SHIFT) - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      SWAP     = 2'd2,
      FADE_IN  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] level_q, level_d;
   logic [1:0]    map_q, map_d, pend_map_q, pend_map_d;
   logic [2:0]    pal_q, pal_d, pend_pal_q, pend_pal_d;
   logic          swap_done_q, swap_done_d;
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic          pv_q;

   // Multiply by the pre-edge level and keep the floor of the divide by MAX_LEVEL.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [LW-1:0] l);
      logic [PW-1:0] p;
      p = PW'(c) * PW'(l);
      return p[LEVEL_SHIFT +: 8];
   endfunction

   // Next-state logic for the fade sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      map_d       = map_q;
      pal_d       = pal_q;
      pend_map_d  = pend_map_q;
      pend_pal_d  = pend_pal_q;
      swap_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A frame_start coinciding with the accepted request is deliberately dropped.
            if (map_req && ({map_req_idx, pal_req_idx} != {map_q, pal_q})) begin
               pend_map_d = map_req_idx;
               pend_pal_d = pal_req_idx;
               cnt_d      = '0;
               state_d    = FADE_OUT;
            end
         end
         FADE_OUT: begin
            if (frame_start) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  level_d = level_q - LVL_ONE;
                  if (level_q == LVL_ONE) state_d = SWAP;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         SWAP: begin
            if (frame_start) begin
               map_d       = pend_map_q;
               pal_d       = pend_pal_q;
               swap_done_d = 1'b1;
               cnt_d       = '0;
               state_d     = FADE_IN;
            end
         end
         FADE_IN: begin
            if (frame_start) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  level_d = level_q + LVL_ONE;
                  if (level_q == LVL_PRE) state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pixel scaling uses the level held before this edge.
   always_comb begin
      r_d = pix_valid_in ? scale(R_in, level_q) : 8'd0;
      g_d = pix_valid_in ? scale(G_in, level_q) : 8'd0;
      b_d = pix_valid_in ? scale(B_in, level_q) : 8'd0;
   end

   // State and pixel registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         level_q     <= LVL_MAX;
         map_q       <= '0;
         pal_q       <= '0;
         pend_map_q  <= '0;
         pend_pal_q  <= '0;
         swap_done_q <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         pv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         map_q       <= map_d;
         pal_q       <= pal_d;
         pend_map_q  <= pend_map_d;
         pend_pal_q  <= pend_pal_d;
         swap_done_q <= swap_done_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
         pv_q        <= pix_valid_in;
      end
   end

   assign Map_idx       = map_q;
   assign Palette_idx   = pal_q;
   assign fade_level    = level_q;
   assign busy          = (state_q != IDLE);
   assign swap_done     = swap_done_q;
   assign VGA_R         = r_q;
   assign VGA_G         = g_q;
   assign VGA_B         = b_q;
   assign pix_valid_out = pv_q;

endmodule
